// File: rtl/if_fetch_queue.sv
// Instruction fetch unit with a DEPTH-entry prefetch queue in front of the IF/ID register.
// Define FETCH_PERF_CNT_EN to add the saturating stall_cycles counter output.
module if_fetch_queue #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        valid_out,
  output logic [31:0] inst_out,
  output logic [31:0] pc_out,
  output logic [31:0] pc_plus4_out
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] stall_cycles
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [31:0] NOP = 32'h0000_0013;

  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return pc & ~32'h0000_0003;
  endfunction

  logic [31:0]      fetch_pc;
  logic             req_p0;
  logic             vld_p1;
  logic [31:0]      pc_p1;
  logic [31:0]      q_inst [DEPTH];
  logic [31:0]      q_pc   [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] occupancy;
  logic             vld_p2;
  logic             consume;
  logic             write;

  // Occupancy counts the in-flight response as already queued, so the queue can never overflow.
  always_comb begin
    vld_p2    = (count != '0);
    consume   = vld_p2 && !stall && !redirect;
    write     = vld_p1 && !redirect;
    occupancy = count - CNT_W'(consume) + CNT_W'(vld_p1);
    req_p0    = !rst && !redirect && (occupancy < DEPTH_C);
  end

  // p0 -> p1: request issue and in-flight tracking
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
      vld_p1   <= 1'b0;
    end else if (redirect) begin
      fetch_pc <= align_pc(redirect_pc);
      vld_p1   <= 1'b0;
    end else begin
      if (req_p0) fetch_pc <= fetch_pc + 32'd4;
      vld_p1 <= req_p0;
    end
  end

  always_ff @(posedge clk) begin
    if (req_p0) pc_p1 <= fetch_pc;
  end

  // p1 -> p2: response capture into the queue tail
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (redirect) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (consume) rd_ptr <= rd_ptr + 1'b1;
      if (write)   wr_ptr <= wr_ptr + 1'b1;
      count <= count + CNT_W'(write) - CNT_W'(consume);
    end
  end

  always_ff @(posedge clk) begin
    if (write) begin
      q_inst[wr_ptr] <= imem_rdata;
      q_pc[wr_ptr]   <= pc_p1;
    end
  end

  // p2: head of queue drives the IF/ID inputs
  always_comb begin
    valid_out    = vld_p2;
    inst_out     = NOP;
    pc_out       = '0;
    pc_plus4_out = '0;
    if (vld_p2) begin
      inst_out     = q_inst[rd_ptr];
      pc_out       = q_pc[rd_ptr];
      pc_plus4_out = q_pc[rd_ptr] + 32'd4;
    end
  end

  assign imem_req  = req_p0;
  assign imem_addr = fetch_pc;

`ifdef FETCH_PERF_CNT_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  logic [31:0] stall_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  stall_cnt <= '0;
    else if (vld_p2 && stall) stall_cnt <= sat_inc(stall_cnt);
  end

  assign stall_cycles = stall_cnt;
`endif

  a_count_bound: assert property (@(posedge clk) disable iff (rst) (count <= DEPTH_C));
  a_addr_align:  assert property (@(posedge clk) disable iff (rst) (fetch_pc[1:0] == 2'b00));

endmodule

// File: tb/tb_if_fetch_queue.sv
// Bench for if_fetch_queue: DEPTH=2 and DEPTH=4 lanes checked every cycle against a
// transaction-level queue model, plus a RESET_PC=FFFF_FFF8 instance for address wrap.
`timescale 1ns/1ps
module tb_if_fetch_queue;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] key;
  int          n_chk  = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } ent_t;

  for (genvar g = 0; g < 2; g++) begin : lane
    localparam int D = (g == 0) ? 2 : 4;

    logic        imem_req;
    logic        valid_out;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] inst_out;
    logic [31:0] pc_out;
    logic [31:0] pc_plus4_out;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] stall_cycles;
`endif

    if_fetch_queue #(.RESET_PC(32'h0000_0000), .DEPTH(D)) dut (
      .clk(clk),
      .rst(rst),
      .imem_req(imem_req),
      .imem_addr(imem_addr),
      .imem_rdata(imem_rdata),
      .stall(stall),
      .redirect(redirect),
      .redirect_pc(redirect_pc),
      .valid_out(valid_out),
      .inst_out(inst_out),
      .pc_out(pc_out),
      .pc_plus4_out(pc_plus4_out)
`ifdef FETCH_PERF_CNT_EN
      ,
      .stall_cycles(stall_cycles)
`endif
    );

    // Memory answers one cycle after a request; garbage otherwise.
    always @(posedge clk) imem_rdata <= imem_req ? (imem_addr ^ key) : 32'hDEAD_BEEF;

    ent_t        q[$];
    logic        infl;
    ent_t        infl_e;
    logic [31:0] fpc;
    logic [31:0] perf;

    always @(posedge clk or posedge rst) begin
      int   used;
      logic take;
      logic req;
      if (rst) begin
        q.delete();
        infl <= 1'b0;
        fpc  <= 32'h0;
        perf <= 32'h0;
      end else begin
        if (q.size() > 0 && stall && perf != 32'hFFFF_FFFF) perf <= perf + 32'd1;
        if (redirect) begin
          q.delete();
          infl <= 1'b0;
          fpc  <= redirect_pc & ~32'h3;
        end else begin
          take = (q.size() > 0) && !stall;
          used = q.size() - int'(take) + int'(infl);
          req  = (used < D);
          if (take) void'(q.pop_front());
          if (infl) q.push_back(infl_e);
          infl <= req;
          if (req) begin
            infl_e <= {fpc ^ key, fpc};
            fpc    <= fpc + 32'd4;
          end
        end
      end
    end

    always @(negedge clk) begin
      logic        ev;
      logic        take;
      int          used;
      logic [31:0] e_inst;
      logic [31:0] e_pc;
      logic [31:0] e_pc4;
      ev     = (q.size() != 0);
      take   = ev && !stall && !redirect;
      used   = q.size() - int'(take) + int'(infl);
      e_inst = NOP;
      e_pc   = 32'h0;
      e_pc4  = 32'h0;
      if (ev) begin
        e_inst = q[0].inst;
        e_pc   = q[0].pc;
        e_pc4  = q[0].pc + 32'd4;
      end
      chk($sformatf("lane%0d valid_out", g), 32'(valid_out), 32'(ev));
      chk($sformatf("lane%0d inst_out", g), inst_out, e_inst);
      chk($sformatf("lane%0d pc_out", g), pc_out, e_pc);
      chk($sformatf("lane%0d pc_plus4_out", g), pc_plus4_out, e_pc4);
      chk($sformatf("lane%0d imem_req", g), 32'(imem_req), 32'(!rst && !redirect && used < D));
      chk($sformatf("lane%0d imem_addr", g), imem_addr, fpc);
`ifdef FETCH_PERF_CNT_EN
      chk($sformatf("lane%0d stall_cycles", g), stall_cycles, perf);
`endif
    end
  end

  logic        hi_req;
  logic        hi_valid;
  logic [31:0] hi_addr;
  logic [31:0] hi_rdata;
  logic [31:0] hi_inst;
  logic [31:0] hi_pc;
  logic [31:0] hi_pc4;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] hi_stall_cycles;
`endif

  if_fetch_queue #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(2)) dut_hi (
    .clk(clk),
    .rst(rst),
    .imem_req(hi_req),
    .imem_addr(hi_addr),
    .imem_rdata(hi_rdata),
    .stall(1'b0),
    .redirect(1'b0),
    .redirect_pc(32'h0),
    .valid_out(hi_valid),
    .inst_out(hi_inst),
    .pc_out(hi_pc),
    .pc_plus4_out(hi_pc4)
`ifdef FETCH_PERF_CNT_EN
    ,
    .stall_cycles(hi_stall_cycles)
`endif
  );

  always @(posedge clk) hi_rdata <= hi_req ? hi_addr : 32'hDEAD_BEEF;

  // Called just after rst deasserts, with key = 0 so data equals address.
  task automatic check_startup();
    logic [31:0] exp_hi [5];
    exp_hi = '{32'h0, 32'h0, 32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0};
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("startup imem_addr", lane[0].imem_addr, 32'(4 * k));
      chk("startup valid_out", 32'(lane[0].valid_out), (k >= 2) ? 32'd1 : 32'd0);
      chk("startup hi valid_out", 32'(hi_valid), (k >= 2) ? 32'd1 : 32'd0);
      if (k >= 2) begin
        chk("startup inst_out", lane[0].inst_out, 32'(4 * (k - 2)));
        chk("startup d4 inst_out", lane[1].inst_out, 32'(4 * (k - 2)));
        chk("wrap pc_out", hi_pc, exp_hi[k]);
        chk("wrap inst_out", hi_inst, exp_hi[k]);
      end
      if (k == 3) chk("wrap pc_plus4_out", hi_pc4, 32'h0);
    end
  endtask

  initial begin
    logic [31:0] exp_addr [4];
    rst         = 1'b1;
    stall       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    key         = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset valid_out", 32'(lane[0].valid_out), 32'd0);
    chk("reset inst_out", lane[0].inst_out, NOP);
    chk("reset pc_out", lane[0].pc_out, 32'h0);
    chk("reset imem_req", 32'(lane[0].imem_req), 32'd0);

    @(posedge clk); #1 rst = 1'b0;
    check_startup();

    // One stall cycle leaves the DEPTH=4 lane with 2 queued and 1 in flight.
    @(posedge clk); #1 stall = 1'b1;
    @(posedge clk); #1 stall = 1'b0; redirect = 1'b1; redirect_pc = 32'h0000_0100; key = 32'hA5A5_0000;
    @(negedge clk);
    chk("redirect d4 head present", 32'(lane[1].valid_out), 32'd1);
    chk("redirect imem_req", 32'(lane[1].imem_req), 32'd0);
    @(posedge clk); #1 redirect = 1'b0;
    exp_addr = '{32'h100, 32'h104, 32'h108, 32'h10C};
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("redirect imem_addr", lane[1].imem_addr, exp_addr[k]);
      chk("redirect valid_out", 32'(lane[1].valid_out), (k >= 2) ? 32'd1 : 32'd0);
      if (k == 2) begin
        chk("redirect pc_out", lane[1].pc_out, 32'h100);
        chk("redirect pc_plus4_out", lane[1].pc_plus4_out, 32'h104);
        chk("redirect inst_out", lane[1].inst_out, 32'hA5A5_0100);
        chk("redirect d2 pc_out", lane[0].pc_out, 32'h100);
      end
      if (k == 3) chk("redirect next pc_out", lane[1].pc_out, 32'h104);
    end

    // Long stall: head frozen, DEPTH=2 lane stops requesting.
    @(posedge clk); #1 stall = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("stall pc_out frozen", lane[0].pc_out, 32'h108);
      chk("stall d4 pc_out frozen", lane[1].pc_out, 32'h108);
      chk("stall imem_req", 32'(lane[0].imem_req), 32'd0);
    end
    @(posedge clk); #1 stall = 1'b0;
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      chk("release order", lane[0].pc_out, 32'(32'h108 + 4 * j));
      chk("release d4 order", lane[1].pc_out, 32'(32'h108 + 4 * j));
      if (j == 1) chk("release inst_out", lane[0].inst_out, 32'hA5A5_010C);
    end

    // Redirect while stalled with a misaligned target.
    @(posedge clk); #1 stall = 1'b1;
    repeat (3) @(posedge clk);
    #1 redirect = 1'b1; redirect_pc = 32'h0000_0203;
    @(negedge clk);
    chk("redirect+stall imem_req", 32'(lane[0].imem_req), 32'd0);
    @(posedge clk); #1 redirect = 1'b0; stall = 1'b0;
    exp_addr = '{32'h200, 32'h204, 32'h208, 32'h20C};
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("redirect+stall imem_addr", lane[0].imem_addr, exp_addr[k]);
      chk("redirect+stall valid_out", 32'(lane[0].valid_out), (k >= 2) ? 32'd1 : 32'd0);
      if (k >= 2) chk("redirect+stall pc_out", lane[0].pc_out, exp_addr[k - 2]);
    end

    // Asynchronous reset in mid-cycle with a response in flight.
    key = 32'h0;
    @(negedge clk); #2 rst = 1'b1;
    #1;
    chk("async rst valid_out", 32'(lane[0].valid_out), 32'd0);
    chk("async rst inst_out", lane[0].inst_out, NOP);
    chk("async rst pc_out", lane[0].pc_out, 32'h0);
    chk("async rst pc_plus4_out", lane[0].pc_plus4_out, 32'h0);
    chk("async rst imem_req", 32'(lane[0].imem_req), 32'd0);
    chk("async rst d4 valid_out", 32'(lane[1].valid_out), 32'd0);
`ifdef FETCH_PERF_CNT_EN
    chk("async rst stall_cycles", lane[0].stall_cycles, 32'h0);
`endif
    @(posedge clk); #1 rst = 1'b0;
    check_startup();

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
